// File: rtl/selection_load_scheduler.sv
// Round-robin arbiter and serial-load sequencer for the 8-slot selection storer.
// One frame at a time: GRANT, DATA_W shift cycles, display pulse, then a short gap.
module selection_load_scheduler #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 12,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     ten_MHz_synch_in,
    input  logic                     reset_n_in,
    input  logic                     enable_in,
    input  logic [NUM_CH-1:0]        req_in,
    input  logic [NUM_CH*DATA_W-1:0] req_data_in,
    output logic [NUM_CH-1:0]        grant_out,
    output logic [2:0]               queue_out,
    output logic                     data_ctrl_out,
    output logic                     serial_out,
    output logic                     safe_switch_out,
    output logic                     displaying_trigger_out,
    output logic                     busy_out
);
    localparam int SEL_W = 3;
    localparam int BIT_W = $clog2(DATA_W);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, SHIFT, DISP, GAP} state_t;

    state_t             r_state, w_state_next;
    logic [SEL_W-1:0]   r_rr_ptr, w_rr_next;
    logic [DATA_W-1:0]  r_shift, w_shift_next;
    logic [BIT_W-1:0]   r_bit_cnt, w_bit_next;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_next;
    logic [NUM_CH-1:0]  r_grant, w_grant_next;
    logic [SEL_W-1:0]   r_queue, w_queue_next;
    logic               r_data_ctrl, w_data_ctrl_next;
    logic               r_serial, w_serial_next;
    logic               r_safe, w_safe_next;
    logic               r_disp_n, w_disp_n_next;
    logic               r_busy, w_busy_next;

    logic [DATA_W-1:0]  w_word [NUM_CH];
    logic [SEL_W-1:0]   w_pick;
    logic               w_found;
    logic               w_start;
    logic               w_launch;
    logic [BIT_W-1:0]   w_bit_inc;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_word
        assign w_word[gi] = req_data_in[gi*DATA_W +: DATA_W];
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && req_in[(int'(r_rr_ptr) + i) % NUM_CH]) begin
                w_found = 1'b1;
                w_pick  = SEL_W'((int'(r_rr_ptr) + i) % NUM_CH);
            end
        end
    end

    assign w_start   = enable_in && w_found;
    assign w_bit_inc = r_bit_cnt + BIT_W'(1);

    always_comb begin
        w_state_next     = r_state;
        w_rr_next        = r_rr_ptr;
        w_shift_next     = r_shift;
        w_bit_next       = r_bit_cnt;
        w_gap_next       = r_gap_cnt;
        w_grant_next     = '0;
        w_queue_next     = r_queue;
        w_data_ctrl_next = 1'b0;
        w_serial_next    = 1'b0;
        w_safe_next      = 1'b1;
        w_disp_n_next    = 1'b1;
        w_busy_next      = r_busy;
        w_launch         = 1'b0;

        case (r_state)
            IDLE: begin
                w_busy_next = 1'b0;
                w_launch    = w_start;
            end
            GRANT: begin
                w_state_next     = SHIFT;
                w_bit_next       = '0;
                w_data_ctrl_next = 1'b1;
                w_safe_next      = 1'b0;
                w_serial_next    = r_shift[0];
            end
            SHIFT: begin
                if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                    w_state_next  = DISP;
                    w_bit_next    = '0;
                    w_disp_n_next = 1'b0;
                end else begin
                    w_bit_next       = w_bit_inc;
                    w_data_ctrl_next = 1'b1;
                    w_safe_next      = 1'b0;
                    w_serial_next    = r_shift[w_bit_inc];
                end
            end
            DISP: begin
                w_gap_next = '0;
                if (GAP_CYCLES == 0) begin
                    w_state_next = IDLE;
                    w_busy_next  = 1'b0;
                    w_launch     = w_start;
                end else begin
                    w_state_next = GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_next = IDLE;
                    w_busy_next  = 1'b0;
                    w_gap_next   = '0;
                    // The final gap cycle arbitrates so back-to-back frames stay gap-aligned.
                    w_launch     = w_start;
                end else begin
                    w_gap_next = r_gap_cnt + GAP_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_launch) begin
            w_state_next = GRANT;
            w_grant_next = NUM_CH'(1) << w_pick;
            w_queue_next = w_pick;
            w_shift_next = w_word[w_pick];
            w_rr_next    = (w_pick == SEL_W'(NUM_CH - 1)) ? '0 : w_pick + SEL_W'(1);
            w_busy_next  = 1'b1;
        end
    end

    always_ff @(posedge ten_MHz_synch_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_grant     <= '0;
            r_queue     <= '0;
            r_data_ctrl <= 1'b0;
            r_serial    <= 1'b0;
            r_safe      <= 1'b1;
            r_disp_n    <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_next;
            r_gap_cnt   <= w_gap_next;
            r_grant     <= w_grant_next;
            r_queue     <= w_queue_next;
            r_data_ctrl <= w_data_ctrl_next;
            r_serial    <= w_serial_next;
            r_safe      <= w_safe_next;
            r_disp_n    <= w_disp_n_next;
            r_busy      <= w_busy_next;
        end
    end

    assign grant_out              = r_grant;
    assign queue_out              = r_queue;
    assign data_ctrl_out          = r_data_ctrl;
    assign serial_out             = r_serial;
    assign safe_switch_out        = r_safe;
    assign displaying_trigger_out = r_disp_n;
    assign busy_out               = r_busy;

endmodule

// File: tb/tb_selection_load_scheduler.sv
// Directed bench for selection_load_scheduler: reset, single frame, round-robin,
// enable gating, mid-frame input changes and asynchronous reset.
module tb_selection_load_scheduler;
    logic        clk;
    logic        reset_n_in;
    logic        enable_in;
    logic [7:0]  req_in;
    logic [95:0] req_data_in;
    logic [7:0]  grant_out;
    logic [2:0]  queue_out;
    logic        data_ctrl_out;
    logic        serial_out;
    logic        safe_switch_out;
    logic        displaying_trigger_out;
    logic        busy_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    selection_load_scheduler dut (
        .ten_MHz_synch_in      (clk),
        .reset_n_in            (reset_n_in),
        .enable_in             (enable_in),
        .req_in                (req_in),
        .req_data_in           (req_data_in),
        .grant_out             (grant_out),
        .queue_out             (queue_out),
        .data_ctrl_out         (data_ctrl_out),
        .serial_out            (serial_out),
        .safe_switch_out       (safe_switch_out),
        .displaying_trigger_out(displaying_trigger_out),
        .busy_out              (busy_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {grant, queue, data_ctrl, serial, safe, disp_n, busy} in the idle/reset state
    localparam logic [15:0] IDLE_VEC = {8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    function automatic logic [15:0] out_vec();
        return {grant_out, queue_out, data_ctrl_out, serial_out,
                safe_switch_out, displaying_trigger_out, busy_out};
    endfunction

    task automatic set_word(input int slot, input logic [11:0] w);
        req_data_in[slot*12 +: 12] = w;
    endtask

    task automatic do_reset();
        reset_n_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_n_in = 1'b1;
    endtask

    // Waits for a grant, then follows the frame to its display pulse, rebuilding the word
    // the storer would receive. action at bit 5: 1 = drop enable, 2 = disturb requests/data.
    task automatic frame(input string tag, input logic [7:0] exp_g, input logic [2:0] exp_q,
                         input logic [11:0] exp_w, input int action,
                         output int waited, output int t_grant);
        logic [11:0] got;
        int n;
        got = '0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_out == 8'h00 && n < 40);
        waited  = n;
        t_grant = cyc;
        check({tag, "_grant"}, grant_out, exp_g);
        check({tag, "_gq"}, {busy_out, queue_out}, {1'b1, exp_q});
        for (int b = 0; b < 12; b++) begin
            @(negedge clk);
            if (b == 0) check({tag, "_pulse"}, grant_out, 8'h00);
            check({tag, "_shift"}, {data_ctrl_out, safe_switch_out, displaying_trigger_out, queue_out},
                  {1'b1, 1'b0, 1'b1, exp_q});
            got[b] = serial_out;
            if (b == 5 && action == 1) enable_in = 1'b0;
            if (b == 5 && action == 2) begin
                req_in      = 8'h80;
                req_data_in = ~req_data_in;
            end
        end
        @(negedge clk);
        check({tag, "_disp"}, {data_ctrl_out, safe_switch_out, displaying_trigger_out, queue_out},
              {1'b0, 1'b1, 1'b0, exp_q});
        check({tag, "_word"}, got, exp_w);
        $display("frame %s: grant=%h slot=%0d word=%h waited=%0d", tag, exp_g, exp_q, got, waited);
    endtask

    initial begin
        #(100 * 5000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, tg, tprev, seen;
        logic [11:0] wk;
        reset_n_in  = 1'b0;
        enable_in   = 1'b0;
        req_in      = 8'h00;
        req_data_in = '0;

        // T1 reset
        @(negedge clk);
        check("t1_reset", out_vec(), IDLE_VEC);
        @(negedge clk);
        check("t1_reset_hold", out_vec(), IDLE_VEC);
        reset_n_in = 1'b1;
        @(negedge clk);

        // T2 single frame, slot 2 = A5C (LSB first 0,0,1,1,1,0,1,0,0,1,0,1)
        enable_in = 1'b1;
        set_word(2, 12'hA5C);
        req_in = 8'h04;
        frame("t2", 8'h04, 3'd2, 12'hA5C, 0, w, tg);
        check("t2_latency", w, 1);
        req_in = 8'h00;
        @(negedge clk);
        check("t2_gap1", {displaying_trigger_out, busy_out, queue_out}, {1'b1, 1'b1, 3'd2});
        @(negedge clk);
        check("t2_gap2", {displaying_trigger_out, busy_out, queue_out}, {1'b1, 1'b1, 3'd2});
        @(negedge clk);
        check("t2_idle", {busy_out, grant_out, queue_out}, {1'b0, 8'h00, 3'd2});

        // T3 round-robin with all requests held: 0..7,0, 16 cycles apart
        do_reset();
        for (int k = 0; k < 8; k++) set_word(k, 12'h0C3 + 12'(k) * 12'h101);
        req_in = 8'hFF;
        tprev  = 0;
        for (int k = 0; k < 9; k++) begin
            wk = 12'h0C3 + 12'(k % 8) * 12'h101;
            frame($sformatf("t3_%0d", k), 8'(1 << (k % 8)), 3'(k % 8), wk, 0, w, tg);
            if (k > 0) check($sformatf("t3_space_%0d", k), tg - tprev, 16);
            tprev = tg;
        end
        req_in = 8'h00;
        repeat (4) @(negedge clk);

        // T4 enable gating with requests on slots 0 and 4
        do_reset();
        set_word(0, 12'h3C7);
        set_word(4, 12'h81E);
        enable_in = 1'b1;
        req_in    = 8'h11;
        frame("t4a", 8'h01, 3'd0, 12'h3C7, 1, w, tg);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (grant_out != 8'h00) seen = 1;
        end
        check("t4_nogrant", seen, 0);
        check("t4_idle", out_vec(), {8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        enable_in = 1'b1;
        frame("t4b", 8'h10, 3'd4, 12'h81E, 0, w, tg);
        check("t4b_latency", w, 1);
        req_in = 8'h00;
        repeat (4) @(negedge clk);

        // T5 disturb req_in/req_data_in mid-SHIFT; frame must keep its captured word
        set_word(5, 12'h6B9);
        req_in = 8'h20;
        frame("t5", 8'h20, 3'd5, 12'h6B9, 2, w, tg);
        req_in = 8'h00;
        repeat (4) @(negedge clk);

        // T6 async reset at SHIFT bit 5, then rr pointer must be back at 0
        set_word(1, 12'hFFF);
        req_in = 8'h02;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (grant_out == 8'h00 && w < 40);
        check("t6_grant", grant_out, 8'h02);
        repeat (6) @(negedge clk);
        check("t6_bit5", {data_ctrl_out, serial_out, busy_out}, {1'b1, 1'b1, 1'b1});
        #10 reset_n_in = 1'b0;
        #1 check("t6_async", out_vec(), IDLE_VEC);
        @(negedge clk);
        check("t6_hold", out_vec(), IDLE_VEC);
        reset_n_in = 1'b1;
        set_word(0, 12'h2D4);
        set_word(7, 12'h0FF);
        req_in = 8'h81;  // slot 7 would win if the pointer were not reset
        frame("t6", 8'h01, 3'd0, 12'h2D4, 0, w, tg);
        req_in = 8'h00;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
